// File: rtl/video_timing_gen.sv
// Programmable raster timing generator. Config and sync polarities are
// shadowed while idle and at each frame boundary. Stage 0 issues a pixel
// request ahead of display. Sync, active and marker flags are delayed by
// PIX_LAT cycles so that de_o lines up with the pixel data the source returns.
module video_timing_gen #(
    parameter int H_WIDTH    = 16,
    parameter int V_WIDTH    = 16,
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int PIX_LAT    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en_i,
    input  logic [H_WIDTH-1:0]             hfp_i,
    input  logic [H_WIDTH-1:0]             hsw_i,
    input  logic [H_WIDTH-1:0]             hbp_i,
    input  logic [H_WIDTH-1:0]             hact_i,
    input  logic [V_WIDTH-1:0]             vfp_i,
    input  logic [V_WIDTH-1:0]             vsw_i,
    input  logic [V_WIDTH-1:0]             vbp_i,
    input  logic [V_WIDTH-1:0]             vact_i,
    input  logic                           hpol_i,
    input  logic                           vpol_i,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_i,
    output logic                           req_o,
    output logic [H_WIDTH-1:0]             x_o,
    output logic [V_WIDTH-1:0]             y_o,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_o,
    output logic                           hsync_o,
    output logic                           vsync_o,
    output logic                           de_o,
    output logic                           sof_o,
    output logic                           eol_o
);

    // Two extra bits keep the sum of four fields from wrapping.
    localparam int HW = H_WIDTH + 2;
    localparam int VW = V_WIDTH + 2;

    logic [H_WIDTH-1:0] s_hfp, s_hsw, s_hbp, s_hact;
    logic [V_WIDTH-1:0] s_vfp, s_vsw, s_vbp, s_vact;
    logic               s_hpol, s_vpol;

    logic [HW-1:0] h_cnt, hs_beg, hs_end, ha_beg, htot;
    logic [VW-1:0] v_cnt, vs_beg, vs_end, va_beg, vtot;
    logic          tot_ok, h_last, v_last, frame_end, run;
    logic          h_sync, v_sync, active, sof_nxt, eol_nxt;
    logic [H_WIDTH-1:0] x_nxt;
    logic [V_WIDTH-1:0] y_nxt;

    // Index 0 is the stage-0 register, index PIX_LAT drives the outputs.
    logic [PIX_LAT:0] vld_pipe, hs_pipe, vs_pipe, sof_pipe, eol_pipe;

    // Region boundaries: front porch, sync, back porch, active.
    assign hs_beg = HW'(s_hfp);
    assign hs_end = hs_beg + HW'(s_hsw);
    assign ha_beg = hs_end + HW'(s_hbp);
    assign htot   = ha_beg + HW'(s_hact);
    assign vs_beg = VW'(s_vfp);
    assign vs_end = vs_beg + VW'(s_vsw);
    assign va_beg = vs_end + VW'(s_vbp);
    assign vtot   = va_beg + VW'(s_vact);

    // A zero total gives all-ones here, which the counters never reach.
    assign tot_ok    = (htot != '0) && (vtot != '0);
    assign h_last    = (h_cnt == htot - HW'(1));
    assign v_last    = (v_cnt == vtot - VW'(1));
    assign frame_end = tot_ok && h_last && v_last;
    assign run       = en_i && tot_ok;

    // Shadow config: track inputs while idle, otherwise only at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_hfp  <= '0; s_hsw <= '0; s_hbp <= '0; s_hact <= '0;
            s_vfp  <= '0; s_vsw <= '0; s_vbp <= '0; s_vact <= '0;
            s_hpol <= 1'b1;
            s_vpol <= 1'b1;
        end else if (!en_i || frame_end) begin
            s_hfp  <= hfp_i; s_hsw <= hsw_i; s_hbp <= hbp_i; s_hact <= hact_i;
            s_vfp  <= vfp_i; s_vsw <= vsw_i; s_vbp <= vbp_i; s_vact <= vact_i;
            s_hpol <= hpol_i;
            s_vpol <= vpol_i;
        end
    end

    // Raster counters; parked at the origin while idle or unconfigured.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Region decode; a zero-width field yields an empty compare range.
    assign h_sync  = run && (h_cnt >= hs_beg) && (h_cnt < hs_end);
    assign v_sync  = run && (v_cnt >= vs_beg) && (v_cnt < vs_end);
    assign active  = run && (h_cnt >= ha_beg) && (v_cnt >= va_beg);
    assign x_nxt   = active ? H_WIDTH'(h_cnt - ha_beg) : '0;
    assign y_nxt   = active ? V_WIDTH'(v_cnt - va_beg) : '0;
    assign sof_nxt = active && (x_nxt == '0) && (y_nxt == '0);
    assign eol_nxt = active && h_last;

    // Stage 0 plus the PIX_LAT-deep delay line for timing flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            hs_pipe  <= '0;
            vs_pipe  <= '0;
            sof_pipe <= '0;
            eol_pipe <= '0;
            x_o      <= '0;
            y_o      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[PIX_LAT-1:0], active};
            hs_pipe  <= {hs_pipe[PIX_LAT-1:0],  h_sync};
            vs_pipe  <= {vs_pipe[PIX_LAT-1:0],  v_sync};
            sof_pipe <= {sof_pipe[PIX_LAT-1:0], sof_nxt};
            eol_pipe <= {eol_pipe[PIX_LAT-1:0], eol_nxt};
            x_o      <= x_nxt;
            y_o      <= y_nxt;
        end
    end

    // Capture returned pixel only when the next output cycle is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= '0;
        end else begin
            data_o <= vld_pipe[PIX_LAT-1] ? data_i : '0;
        end
    end

    assign req_o   = vld_pipe[0];
    assign de_o    = vld_pipe[PIX_LAT];
    assign sof_o   = sof_pipe[PIX_LAT];
    assign eol_o   = eol_pipe[PIX_LAT];
    assign hsync_o = ~(hs_pipe[PIX_LAT] ^ s_hpol);
    assign vsync_o = ~(vs_pipe[PIX_LAT] ^ s_vpol);

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (PIX_LAT 1, 2, 8) share one
// stimulus stream. A frame-position model predicts every output each cycle,
// and window counts over whole frames pin the model to hand-derived numbers.
module tb_video_timing_gen;

    localparam int MAXC = 8192;

    typedef struct packed {
        logic        req;
        logic [15:0] x;
        logic [15:0] y;
        logic        hs;
        logic        vs;
        logic        sof;
        logic        eol;
    } st_t;

    logic        clk = 1'b0;
    logic        rst, en, hpol, vpol;
    logic [15:0] hfp, hsw, hbp, hact, vfp, vsw, vbp, vact;

    logic [2:0][23:0] din, dout;
    logic [2:0][15:0] xw, yw;
    logic [2:0]       reqw, hsw_o, vsw_o, dew, sofw, eolw;

    int lats[3] = '{1, 2, 8};

    always #5 clk = ~clk;

    video_timing_gen #(.PIX_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .en_i(en),
        .hfp_i(hfp), .hsw_i(hsw), .hbp_i(hbp), .hact_i(hact),
        .vfp_i(vfp), .vsw_i(vsw), .vbp_i(vbp), .vact_i(vact),
        .hpol_i(hpol), .vpol_i(vpol), .data_i(din[0]),
        .req_o(reqw[0]), .x_o(xw[0]), .y_o(yw[0]), .data_o(dout[0]),
        .hsync_o(hsw_o[0]), .vsync_o(vsw_o[0]), .de_o(dew[0]),
        .sof_o(sofw[0]), .eol_o(eolw[0]));

    video_timing_gen #(.PIX_LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .en_i(en),
        .hfp_i(hfp), .hsw_i(hsw), .hbp_i(hbp), .hact_i(hact),
        .vfp_i(vfp), .vsw_i(vsw), .vbp_i(vbp), .vact_i(vact),
        .hpol_i(hpol), .vpol_i(vpol), .data_i(din[1]),
        .req_o(reqw[1]), .x_o(xw[1]), .y_o(yw[1]), .data_o(dout[1]),
        .hsync_o(hsw_o[1]), .vsync_o(vsw_o[1]), .de_o(dew[1]),
        .sof_o(sofw[1]), .eol_o(eolw[1]));

    video_timing_gen #(.PIX_LAT(8)) u_l8 (
        .clk(clk), .rst(rst), .en_i(en),
        .hfp_i(hfp), .hsw_i(hsw), .hbp_i(hbp), .hact_i(hact),
        .vfp_i(vfp), .vsw_i(vsw), .vbp_i(vbp), .vact_i(vact),
        .hpol_i(hpol), .vpol_i(vpol), .data_i(din[2]),
        .req_o(reqw[2]), .x_o(xw[2]), .y_o(yw[2]), .data_o(dout[2]),
        .hsync_o(hsw_o[2]), .vsync_o(vsw_o[2]), .de_o(dew[2]),
        .sof_o(sofw[2]), .eol_o(eolw[2]));

    // ---------------- model state ----------------
    st_t  hist[MAXC];
    logic hp_h[MAXC];
    logic vp_h[MAXC];
    int   sh[8];
    logic shp_h, shp_v;
    int   pos, n, last_rst;
    int   total, bad;
    bit   win;
    int   c_de[3];
    int   c_hs, c_vs, c_sof, c_eol, c_req;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", nm, n, act, exp);
        end
    endtask

    function automatic logic [23:0] pat(input st_t s);
        return {s.y[7:0], s.x[7:0], s.x[7:0] ^ s.y[7:0] ^ 8'hA5};
    endfunction

    function automatic st_t stage_at(input int k);
        st_t z = '0;
        if (k >= 1 && k >= last_rst) return hist[k];
        return z;
    endfunction

    // Predict stage-0 values for the coming edge from the frame position.
    task automatic model_edge();
        st_t s = '0;
        int ht, vt, h, v, hb, vb;
        bit lastf = 0;
        n++;
        if (n >= MAXC) begin
            $display("FAIL cycle_budget edge=%0d", n);
            $fatal(1, "cycle budget exhausted");
        end
        if (rst) begin
            foreach (sh[i]) sh[i] = 0;
            shp_h = 1'b1; shp_v = 1'b1;
            pos = 0;
            last_rst = n;
        end else begin
            ht = sh[0] + sh[1] + sh[2] + sh[3];
            vt = sh[4] + sh[5] + sh[6] + sh[7];
            if (en && ht > 0 && vt > 0) begin
                h = pos % ht;
                v = pos / ht;
                hb = sh[0] + sh[1] + sh[2];
                vb = sh[4] + sh[5] + sh[6];
                s.hs  = (h >= sh[0]) && (h < sh[0] + sh[1]);
                s.vs  = (v >= sh[4]) && (v < sh[4] + sh[5]);
                s.req = (h >= hb) && (v >= vb);
                if (s.req) begin
                    s.x   = 16'(h - hb);
                    s.y   = 16'(v - vb);
                    s.sof = (h == hb) && (v == vb);
                    s.eol = (h - hb) == sh[3] - 1;
                end
                lastf = (pos == ht * vt - 1);
                pos = lastf ? 0 : pos + 1;
            end else begin
                pos = 0;
            end
            if (!en || lastf) begin
                sh[0] = int'(hfp); sh[1] = int'(hsw); sh[2] = int'(hbp); sh[3] = int'(hact);
                sh[4] = int'(vfp); sh[5] = int'(vsw); sh[6] = int'(vbp); sh[7] = int'(vact);
                shp_h = hpol; shp_v = vpol;
            end
        end
        hist[n] = s;
        hp_h[n] = shp_h;
        vp_h[n] = shp_v;
    endtask

    task automatic check_dut(input int i);
        int   L = lats[i];
        st_t  s0 = stage_at(n);
        st_t  s = stage_at(n - L);
        string t = $sformatf("L%0d", L);
        chk({t, ".req"}, 64'(reqw[i]), 64'(s0.req));
        chk({t, ".x"},   64'(xw[i]),   64'(s0.x));
        chk({t, ".y"},   64'(yw[i]),   64'(s0.y));
        chk({t, ".de"},  64'(dew[i]),  64'(s.req));
        chk({t, ".sof"}, 64'(sofw[i]), 64'(s.sof));
        chk({t, ".eol"}, 64'(eolw[i]), 64'(s.eol));
        chk({t, ".hsync"}, 64'(hsw_o[i]), 64'(s.hs == hp_h[n]));
        chk({t, ".vsync"}, 64'(vsw_o[i]), 64'(s.vs == vp_h[n]));
        chk({t, ".data"}, 64'(dout[i]), s.req ? 64'(pat(s)) : 64'd0);
    endtask

    // One clock: predict, clock, compare, then answer requests.
    task automatic step();
        st_t s;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_dut(i);
        for (int i = 0; i < 3; i++) begin
            s = stage_at(n - lats[i] + 1);
            din[i] = s.req ? pat(s) : 24'($urandom);
        end
        if (win) begin
            for (int i = 0; i < 3; i++) c_de[i] += int'(dew[i]);
            c_hs  += int'(hsw_o[1]);
            c_vs  += int'(vsw_o[1]);
            c_sof += int'(sofw[1]);
            c_eol += int'(eolw[1]);
            c_req += int'(reqw[1]);
        end
    endtask

    task automatic run(input int c);
        for (int i = 0; i < c; i++) step();
    endtask

    task automatic window(input int c);
        foreach (c_de[i]) c_de[i] = 0;
        c_hs = 0; c_vs = 0; c_sof = 0; c_eol = 0; c_req = 0;
        win = 1;
        run(c);
        win = 0;
    endtask

    task automatic set_cfg(input int a, b, c, d, e, f, g, h);
        hfp = 16'(a); hsw = 16'(b); hbp = 16'(c); hact = 16'(d);
        vfp = 16'(e); vsw = 16'(f); vbp = 16'(g); vact = 16'(h);
    endtask

    // Reload config through an idle gap, then restart.
    task automatic restart(input int a, b, c, d, e, f, g, h);
        en = 1'b0;
        set_cfg(a, b, c, d, e, f, g, h);
        run(2);
        en = 1'b1;
    endtask

    initial begin
        int r;
        total = 0; bad = 0; n = 0; last_rst = 0; pos = 0; win = 0;
        foreach (sh[i]) sh[i] = 0;
        shp_h = 1'b1; shp_v = 1'b1;
        for (int i = 0; i < MAXC; i++) begin
            hist[i] = '0; hp_h[i] = 1'b1; vp_h[i] = 1'b1;
        end
        rst = 1'b1; en = 1'b0; hpol = 1'b1; vpol = 1'b1;
        set_cfg(2, 3, 1, 4, 1, 2, 1, 3);
        for (int i = 0; i < 3; i++) din[i] = 24'($urandom);

        // reset state
        run(2);
        chk("rst.req", 64'(reqw[1]), 0);
        chk("rst.de", 64'(dew[1]), 0);
        chk("rst.hsync", 64'(hsw_o[1]), 0);
        chk("rst.vsync", 64'(vsw_o[1]), 0);
        chk("rst.data", 64'(dout[1]), 0);

        // basic frame: 10-cycle lines, 70-cycle frame
        rst = 1'b0;
        run(3);
        en = 1'b1;
        run(70);
        window(70);
        chk("basic.de", c_de[1], 12);
        chk("basic.de_l1", c_de[0], 12);
        chk("basic.de_l8", c_de[2], 12);
        chk("basic.req", c_req, 12);
        chk("basic.hsync", c_hs, 21);
        chk("basic.vsync", c_vs, 20);
        chk("basic.sof", c_sof, 1);
        chk("basic.eol", c_eol, 3);

        // mid-frame polarity and width change, visible from next frame
        run(25);
        hpol = 1'b0;
        hact = 16'd6;
        run(100);
        window(84);
        chk("pol.hsync_high", c_hs, 63);
        chk("pol.de", c_de[1], 18);
        chk("pol.sof", c_sof, 1);
        chk("pol.eol", c_eol, 3);

        // zero-width sync
        hpol = 1'b1;
        restart(2, 0, 1, 4, 1, 2, 1, 3);
        run(20);
        window(49);
        chk("hsw0.hsync", c_hs, 0);
        chk("hsw0.de", c_de[1], 12);

        // zero active width: counters still cycle vertically
        restart(2, 3, 1, 0, 1, 2, 1, 3);
        run(20);
        window(42);
        chk("hact0.de", c_de[1], 0);
        chk("hact0.req", c_req, 0);
        chk("hact0.vsync", c_vs, 12);

        // all-zero config
        restart(0, 0, 0, 0, 0, 0, 0, 0);
        run(10);
        window(30);
        chk("zero.de", c_de[1], 0);
        chk("zero.req", c_req, 0);
        chk("zero.hsync", c_hs, 0);
        chk("zero.vsync", c_vs, 0);

        // enable drop in the middle of the first active line
        restart(2, 3, 1, 4, 1, 2, 1, 3);
        run(48);
        en = 1'b0;
        step();
        chk("endrop.req", 64'(reqw[1]), 0);
        chk("endrop.de0", 64'(dew[1]), 1);
        step();
        chk("endrop.de1", 64'(dew[1]), 1);
        step();
        chk("endrop.de2", 64'(dew[1]), 0);

        // reset mid-line
        en = 1'b1;
        run(45);
        rst = 1'b1;
        step();
        chk("midrst.req", 64'(reqw[1]), 0);
        chk("midrst.de", 64'(dew[1]), 0);
        chk("midrst.de_l8", 64'(dew[2]), 0);
        chk("midrst.data", 64'(dout[1]), 0);
        chk("midrst.hsync", 64'(hsw_o[1]), 0);
        rst = 1'b0;

        // randomized traffic with mid-frame config churn
        restart(2, 3, 1, 4, 1, 2, 1, 3);
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 999));
            rst = (r < 3);
            if (r >= 3 && r < 8) en = ~en;
            else if (r >= 8 && r < 60) begin
                case ($urandom_range(0, 7))
                    0: hfp  = 16'($urandom_range(0, 4));
                    1: hsw  = 16'($urandom_range(0, 4));
                    2: hbp  = 16'($urandom_range(0, 4));
                    3: hact = 16'($urandom_range(0, 4));
                    4: vfp  = 16'($urandom_range(0, 3));
                    5: vsw  = 16'($urandom_range(0, 3));
                    6: vbp  = 16'($urandom_range(0, 3));
                    default: vact = 16'($urandom_range(0, 3));
                endcase
            end else if (r >= 60 && r < 70) begin
                hpol = 1'($urandom);
                vpol = 1'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
